// File: rtl/bus_fabric.sv
// -----------------------------------------------------------------------------
// bus_fabric
//   Single-master to NSLAVES-slave bus fabric. Each request is address-decoded
//   on the 4-bit page number m_addr[15:12]. The address must also lie in the
//   low 64 KiB. The fabric drives a one-hot chip select to the decoded slave
//   and waits for that slave's ready. It then returns the response to the
//   master as a one-cycle m_ready pulse. The first failing transfer is
//   recorded in a sticky error-capture register.
//
//   Optional feature macro: BUS_FABRIC_TIMEOUT_EN
//     defined   -> ACCESS is bounded by a wait counter. When the limit is
//                  reached the transfer ends with an error.
//     undefined -> no counter. ACCESS waits indefinitely for the slave.
//
// Parameters
//   WIDTH     data/address width (must be > 16)
//   NSLAVES   number of slave ports (1..16)
//   SLV_BASE  per-slave page match value, slave i at [4i+3:4i]
//   SLV_MASK  per-slave page compare mask, slave i at [4i+3:4i]
//   TIMEOUT   ACCESS cycle limit before a bus error (1..255)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   m_req/m_wen/m_addr/m_dout   master request side
//   m_din/m_ready/m_err         master response (registered)
//   s_cs/s_wen/s_addr/s_dout    slave request side (registered)
//   s_din/s_ready               slave responses, slave i data at WIDTH*i
//   err_flag/err_addr/err_wen   sticky first-error capture
//   err_clr                     clears err_flag
//
// state  | meaning
// IDLE   | waiting for m_req; latches request and decode result
// ACCESS | chip select asserted, waiting for selected slave ready / timeout
// DONE   | one-cycle m_ready pulse with m_err/m_din valid
// -----------------------------------------------------------------------------
module bus_fabric #(
  parameter int          WIDTH    = 32,
  parameter int          NSLAVES  = 8,
  parameter logic [63:0] SLV_BASE = 64'h0000_0000_FEDC_0000,
  parameter logic [63:0] SLV_MASK = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_req,
  input  logic                     m_wen,
  input  logic [WIDTH-1:0]         m_addr,
  input  logic [WIDTH-1:0]         m_dout,
  output logic [WIDTH-1:0]         m_din,
  output logic                     m_ready,
  output logic                     m_err,
  output logic [NSLAVES-1:0]       s_cs,
  output logic                     s_wen,
  output logic [WIDTH-1:0]         s_addr,
  output logic [WIDTH-1:0]         s_dout,
  input  logic [NSLAVES*WIDTH-1:0] s_din,
  input  logic [NSLAVES-1:0]       s_ready,
  output logic                     err_flag,
  output logic [WIDTH-1:0]         err_addr,
  output logic                     err_wen,
  input  logic                     err_clr
);

  localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  if (TIMEOUT < 1 || TIMEOUT > 255 || NSLAVES < 1 || NSLAVES > 16 || WIDTH <= 16)
  begin : g_bad_params
    $error("bus_fabric: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NSLAVES-1:0] s_cs_q;
  logic               s_wen_q;
  logic [WIDTH-1:0]   s_addr_q;
  logic [WIDTH-1:0]   s_dout_q;
  logic [WIDTH-1:0]   m_din_q;
  logic               m_ready_q;
  logic               m_err_q;
  logic               err_flag_q;
  logic [WIDTH-1:0]   err_addr_q;
  logic               err_wen_q;

  // Address decode: a loop running from the top index down lets the lowest
  // matching slave overwrite any higher match.
  logic             hit_d;
  logic [SEL_W-1:0] sel_d;
  logic             upper_zero;

  assign upper_zero = (m_addr[WIDTH-1:16] == '0);

  always_comb begin
    hit_d = 1'b0;
    sel_d = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (upper_zero &&
          ((m_addr[15:12] & SLV_MASK[4*i +: 4]) ==
           (SLV_BASE[4*i +: 4] & SLV_MASK[4*i +: 4]))) begin
        hit_d = 1'b1;
        sel_d = SEL_W'(i);
      end
    end
  end

  // Response mux for the latched slave index.
  logic             sel_ready;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = s_ready[i];
        sel_data  = s_din[WIDTH*i +: WIDTH];
      end
    end
  end

  logic timeout_hit;

`ifdef BUS_FABRIC_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // The count starts at 0 on the first ACCESS cycle. Firing at TIMEOUT-1
  // therefore keeps the chip select up for exactly TIMEOUT cycles.
  assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && !sel_ready) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      s_cs_q     <= '0;
      s_wen_q    <= 1'b0;
      s_addr_q   <= '0;
      s_dout_q   <= '0;
      m_din_q    <= '0;
      m_ready_q  <= 1'b0;
      m_err_q    <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
      err_wen_q  <= 1'b0;
    end else begin
      m_ready_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (m_req) begin
            s_addr_q <= m_addr;
            s_wen_q  <= m_wen;
            s_dout_q <= m_dout;
            sel_q    <= sel_d;
            if (hit_d) begin
              s_cs_q  <= NSLAVES'(1) << sel_d;
              state_q <= ACCESS;
            end else begin
              state_q   <= DONE;
              m_ready_q <= 1'b1;
              m_err_q   <= 1'b1;
              m_din_q   <= '0;
            end
          end
        end

        ACCESS: begin
          if (sel_ready) begin
            state_q   <= DONE;
            s_cs_q    <= '0;
            m_ready_q <= 1'b1;
            m_err_q   <= 1'b0;
            m_din_q   <= s_wen_q ? '0 : sel_data;
          end else if (timeout_hit) begin
            state_q   <= DONE;
            s_cs_q    <= '0;
            m_ready_q <= 1'b1;
            m_err_q   <= 1'b1;
            m_din_q   <= '0;
          end
        end

        DONE: begin
          state_q <= IDLE;
          m_err_q <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          s_cs_q  <= '0;
        end
      endcase

      // A new error always sets the flag, even over err_clr. Only the first
      // error is recorded, so an existing capture is never overwritten.
      if (state_q == DONE && m_err_q) begin
        err_flag_q <= 1'b1;
        if (!err_flag_q) begin
          err_addr_q <= s_addr_q;
          err_wen_q  <= s_wen_q;
        end
      end else if (err_clr) begin
        err_flag_q <= 1'b0;
      end
    end
  end

  assign m_din    = m_din_q;
  assign m_ready  = m_ready_q;
  assign m_err    = m_err_q;
  assign s_cs     = s_cs_q;
  assign s_wen    = s_wen_q;
  assign s_addr   = s_addr_q;
  assign s_dout   = s_dout_q;
  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;
  assign err_wen  = err_wen_q;

endmodule

// File: tb/tb_bus_fabric.sv
// -----------------------------------------------------------------------------
// tb_bus_fabric
//   Directed bench for bus_fabric. The slave map is overridden so that pages
//   0,1,2,3 belong to slaves 0..3, page C to slave 4 and page F to slave 7.
//   Page 3 is also claimed by slave 5, so the lowest-index priority is
//   exercised. Page D is unmapped. Slave i returns 0xA000_000i, except slave 3,
//   which returns 0xCAFE_0001.
// -----------------------------------------------------------------------------
module tb_bus_fabric;

  localparam int W  = 32;
  localparam int NS = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             m_req, m_wen, err_clr;
  logic [W-1:0]     m_addr, m_dout, m_din, s_addr, s_dout, err_addr;
  logic             m_ready, m_err, s_wen, err_flag, err_wen;
  logic [NS-1:0]    s_cs, s_ready;
  logic [NS*W-1:0]  s_din;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_fabric #(
    .WIDTH   (W),
    .NSLAVES (NS),
    .SLV_BASE(64'h0000_0000_FE3C_3210),
    .SLV_MASK(64'hFFFF_FFFF_FFFF_FFFF),
    .TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_wen   (m_wen),
    .m_addr  (m_addr),
    .m_dout  (m_dout),
    .m_din   (m_din),
    .m_ready (m_ready),
    .m_err   (m_err),
    .s_cs    (s_cs),
    .s_wen   (s_wen),
    .s_addr  (s_addr),
    .s_dout  (s_dout),
    .s_din   (s_din),
    .s_ready (s_ready),
    .err_flag(err_flag),
    .err_addr(err_addr),
    .err_wen (err_wen),
    .err_clr (err_clr)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and observes each cycle after the request edge N.
  // Observation k shows the value that the master samples at edge N+k.
  // s_ready is raised (all bits) from observation rdy_after onwards.
  task automatic xfer(input logic wen, input logic [W-1:0] addr, input logic [W-1:0] data,
                      input int rdy_after, input logic clr_at_done,
                      output int lat, output logic [W-1:0] din, output logic err,
                      output logic [NS-1:0] cs_or, output int cs_cyc,
                      output logic unstable, output logic rdy_tail);
    @(negedge clk);
    m_req   = 1'b1;
    m_wen   = wen;
    m_addr  = addr;
    m_dout  = data;
    s_ready = (rdy_after == 0) ? '1 : '0;
    lat = -1; din = '0; err = 1'b0; cs_or = '0; cs_cyc = 0; unstable = 1'b0; rdy_tail = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      m_req = 1'b0;
      if (s_cs != '0) begin
        cs_or = cs_or | s_cs;
        cs_cyc++;
        if (s_addr !== addr || s_wen !== wen || s_dout !== data) unstable = 1'b1;
      end
      if (m_ready) begin
        lat = k;
        din = m_din;
        err = m_err;
        if (clr_at_done) err_clr = 1'b1;
        break;
      end
      if (k >= rdy_after) s_ready = '1;
    end
    @(negedge clk);
    err_clr  = 1'b0;
    rdy_tail = m_ready;
    s_ready  = '1;
  endtask

  int            lat, cs_cyc, pulses;
  logic [W-1:0]  din;
  logic          err, unstable, rdy_tail, seen;
  logic [NS-1:0] cs_or;

  initial begin
    reset = 1'b1; m_req = 1'b0; m_wen = 1'b0; err_clr = 1'b0;
    m_addr = '0; m_dout = '0; s_ready = '1;
    for (int i = 0; i < NS; i++) s_din[W*i +: W] = 32'hA000_0000 | i;
    s_din[W*3 +: W] = 32'hCAFE_0001;

    repeat (3) @(negedge clk);
    check("rst_m_ready", m_ready, 0);
    check("rst_m_err", m_err, 0);
    check("rst_m_din", m_din, 0);
    check("rst_s_cs", s_cs, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_addr", err_addr, 0);
    reset = 1'b0;

    // Read from slave 3 with immediate ready; slave 5 also matches page 3.
    xfer(1'b0, 32'h0000_3004, 32'h0, 0, 1'b0, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("rd3_lat", lat, 2);
    check("rd3_cs", cs_or, 8'h08);
    check("rd3_cs_cycles", cs_cyc, 1);
    check("rd3_din", din, 32'hCAFE_0001);
    check("rd3_err", err, 0);
    check("rd3_stable", unstable, 0);
    check("rd3_pulse_tail", rdy_tail, 0);
    check("rd3_m_din_hold", m_din, 32'hCAFE_0001);
    check("rd3_err_flag", err_flag, 0);

    // Write to page C -> slave 4; read data returns 0 for writes.
    xfer(1'b1, 32'h0000_C010, 32'h55, 0, 1'b0, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("wrC_lat", lat, 2);
    check("wrC_cs", cs_or, 8'h10);
    check("wrC_stable", unstable, 0);
    check("wrC_err", err, 0);
    check("wrC_din", din, 0);

    // Read from page F -> slave 7.
    xfer(1'b0, 32'h0000_F004, 32'h0, 0, 1'b0, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("rdF_cs", cs_or, 8'h80);
    check("rdF_din", din, 32'hA000_0007);

    // Slave 0 answers after 5 ACCESS cycles.
    xfer(1'b0, 32'h0000_0ABC, 32'h0, 5, 1'b0, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("slow_lat", lat, 6);
    check("slow_cs_cycles", cs_cyc, 5);
    check("slow_cs", cs_or, 8'h01);
    check("slow_din", din, 32'hA000_0000);
    check("slow_err", err, 0);

    // Unmapped address above 64 KiB.
    xfer(1'b0, 32'h0001_0000, 32'h0, 0, 1'b0, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("unm_lat", lat, 1);
    check("unm_cs", cs_or, 0);
    check("unm_err", err, 1);
    check("unm_din", din, 0);
    check("unm_err_flag", err_flag, 1);
    check("unm_err_addr", err_addr, 32'h0001_0000);
    check("unm_err_wen", err_wen, 0);

    // Unmapped write to page D: no chip select, and the capture is kept.
    xfer(1'b1, 32'h0000_D000, 32'h77, 0, 1'b0, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("unmD_cs", cs_or, 0);
    check("unmD_err", err, 1);
    check("unmD_err_addr_kept", err_addr, 32'h0001_0000);
    check("unmD_err_wen_kept", err_wen, 0);

    // err_clr on its own clears only the flag.
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("clr_flag", err_flag, 0);
    check("clr_addr_kept", err_addr, 32'h0001_0000);

    // A new error in the same cycle as err_clr: the capture wins.
    xfer(1'b1, 32'h0003_0000, 32'h1, 0, 1'b1, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("clrcap_err", err, 1);
    check("clrcap_flag", err_flag, 1);
    check("clrcap_addr", err_addr, 32'h0003_0000);
    check("clrcap_wen", err_wen, 1);

`ifdef BUS_FABRIC_TIMEOUT_EN
    // Slave 3 never answers: 15 ACCESS cycles, then an error. The capture is kept.
    xfer(1'b0, 32'h0000_3000, 32'h0, 1000, 1'b0, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("to_lat", lat, 16);
    check("to_cs_cycles", cs_cyc, 15);
    check("to_cs", cs_or, 8'h08);
    check("to_err", err, 1);
    check("to_din", din, 0);
    check("to_err_addr_kept", err_addr, 32'h0003_0000);
    check("to_err_flag", err_flag, 1);
`else
    // No timeout: ACCESS waits 30 cycles for slave 3, then completes cleanly.
    xfer(1'b0, 32'h0000_3000, 32'h0, 30, 1'b0, lat, din, err, cs_or, cs_cyc, unstable, rdy_tail);
    check("wait_lat", lat, 31);
    check("wait_cs_cycles", cs_cyc, 30);
    check("wait_err", err, 0);
    check("wait_din", din, 32'hCAFE_0001);
    check("wait_err_addr_kept", err_addr, 32'h0003_0000);
`endif

    // Continuous m_req over 9 cycles: one transfer every 3 cycles.
    @(negedge clk);
    s_ready = '1; m_req = 1'b1; m_wen = 1'b0; m_addr = 32'h0000_3004;
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (m_ready) pulses++;
    end
    m_req = 1'b0;
    check("b2b_pulses", pulses, 3);
    check("b2b_m_din", m_din, 32'hCAFE_0001);

    // Reset in the middle of ACCESS.
    repeat (2) @(negedge clk);
    s_ready = '0; m_req = 1'b1; m_wen = 1'b1; m_addr = 32'h0000_3004; m_dout = 32'hDEAD_BEEF;
    @(negedge clk);
    m_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_pre_cs", s_cs, 8'h08);
    check("rstmid_pre_wen", s_wen, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_cs", s_cs, 0);
    check("rstmid_s_wen", s_wen, 0);
    check("rstmid_s_addr", s_addr, 0);
    check("rstmid_s_dout", s_dout, 0);
    check("rstmid_m_din", m_din, 0);
    check("rstmid_m_ready", m_ready, 0);
    check("rstmid_err_flag", err_flag, 0);
    check("rstmid_err_addr", err_addr, 0);
    check("rstmid_err_wen", err_wen, 0);
    reset = 1'b0;
    s_ready = '1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_ready || s_cs != '0) seen = 1'b1;
    end
    check("rstmid_no_ready", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
